infer_accum: RTL and testbench

//  Inference-side reader of the per-pixel weight memory that the training unit writes.

---
 rtl/infer_accum.sv | 147 ++++++++++++++
 tb/tb_infer_accum.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/infer_accum.sv
// Per-class score accumulator over one binarised frame, followed by a serial argmax.
// Optional build macro SCORE_SAT_EN: saturating score adds (default is 16-bit wrap-around).
module infer_accum #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int NCLASS = 10,
    parameter int W_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_stream,
    input  logic                   start_pixel,
    input  logic                   pixel,
    input  logic [NCLASS-1:0][15:0] weights_in,
    output logic [NCLASS-1:0][15:0] scores,
    output logic [3:0]             label,
    output logic                   busy,
    output logic                   done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_ARGMAX,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [NCLASS-1:0][15:0]  r_scores;
    logic [CW-1:0]            r_cnt;
    logic [3:0]               r_idx;
    logic [3:0]               r_best;
    logic [15:0]              r_max;
    logic [3:0]               r_label;
    logic                     r_done;
    logic                     w_enter;
    logic                     w_exit;
    logic                     w_take;

    function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
`ifdef SCORE_SAT_EN
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15])
            return s[16] ? 16'h8000 : 16'h7FFF;
        return s[15:0];
`else
        return a + b;
`endif
    endfunction

    // A restart in the same cycle drops the presented pixel.
    assign w_enter = start_pixel && (r_state == S_ACCUM) && !start_stream;

    generate
        if (W_LAT == 0) begin : g_nodly
            assign w_exit = w_enter;
        end else begin : g_dly
            logic [W_LAT-1:0] r_dly;
            always_ff @(posedge clk) begin
                if (!reset || start_stream)
                    r_dly <= '0;
                else
                    r_dly <= (r_dly << 1) | W_LAT'(w_enter);
            end
            assign w_exit = r_dly[W_LAT-1] && (r_state == S_ACCUM);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (start_stream) begin
            w_next = S_ACCUM;
        end else begin
            case (r_state)
                S_ACCUM:  if (w_exit && (r_cnt == CW'(NPIX - 1))) w_next = S_ARGMAX;
                S_ARGMAX: if (r_idx == 4'(NCLASS - 1)) w_next = S_DONE;
                default:  w_next = r_state;
            endcase
        end
    end

    // Class 0 always seeds the running max; later classes must be strictly greater.
    assign w_take = (r_idx == 4'd0) || ($signed(r_scores[r_idx]) > $signed(r_max));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scores <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_best   <= '0;
            r_max    <= '0;
            r_label  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start_stream) begin
                r_scores <= '0;
                r_cnt    <= '0;
                r_idx    <= '0;
                r_best   <= '0;
                r_max    <= '0;
            end else begin
                case (r_state)
                    S_ACCUM: begin
                        if (w_exit) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (pixel) begin
                                for (int unsigned k = 0; k < NCLASS; k++)
                                    r_scores[k] <= add16(r_scores[k], weights_in[k]);
                            end
                        end
                    end
                    S_ARGMAX: begin
                        if (w_take) begin
                            r_max  <= r_scores[r_idx];
                            r_best <= r_idx;
                        end
                        r_idx <= r_idx + 4'd1;
                        if (r_idx == 4'(NCLASS - 1)) begin
                            r_label <= w_take ? r_idx : r_best;
                            r_done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign scores = r_scores;
    assign label  = r_label;
    assign done   = r_done;
    assign busy   = (r_state == S_ACCUM) || (r_state == S_ARGMAX);

endmodule

// File: tb/tb_infer_accum.sv
// Directed bench for infer_accum: full frames, overflow, restart, and reset during argmax.
module tb_infer_accum;

    localparam int NC = 10;

    logic                clk = 1'b0;
    logic                reset;
    logic                start_stream;
    logic                start_pixel;
    logic                pixel;
    logic [NC-1:0][15:0] weights_in;
    logic [NC-1:0][15:0] scores;
    logic [3:0]          label;
    logic                busy;
    logic                done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int exp_s [NC];

    infer_accum #(
        .IMG_W (28),
        .IMG_H (28),
        .NCLASS(10),
        .W_LAT (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_stream(start_stream),
        .start_pixel (start_pixel),
        .pixel       (pixel),
        .weights_in  (weights_in),
        .scores      (scores),
        .label       (label),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input int got, input int expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic pix(input logic p);
        @(negedge clk);
        start_pixel = 1'b1;
        pixel       = 1'b0;
        @(negedge clk);
        start_pixel = 1'b0;
        pixel       = p;
    endtask

    // mode 0: all pixels 1; mode 1: alternate starting at 0
    task automatic frame(input int mode, input int n);
        for (int i = 0; i < n; i++)
            pix(mode == 0 ? 1'b1 : logic'(i % 2));
    endtask

    task automatic restart(input logic with_pixel);
        @(negedge clk);
        start_stream = 1'b1;
        start_pixel  = with_pixel;
        pixel        = 1'b0;
        @(negedge clk);
        start_stream = 1'b0;
        start_pixel  = 1'b0;
        chk("clear_busy", int'(busy), 1);
        for (int k = 0; k < NC; k++)
            chk($sformatf("clear_s%0d", k), $signed(scores[k]), 0);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int lat;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        pixel = 1'b0;
        chk({tag, "_latency"}, lat, 11);
        @(negedge clk);
        chk({tag, "_done_low"}, int'(done), 0);
        chk({tag, "_busy_low"}, int'(busy), 0);
        chk({tag, "_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic check_res(input string tag, input int lab);
        for (int k = 0; k < NC; k++)
            chk($sformatf("%s_s%0d", tag, k), $signed(scores[k]), exp_s[k]);
        chk({tag, "_label"}, int'(label), lab);
    endtask

    initial begin
        int d0;
        reset        = 1'b0;
        start_stream = 1'b0;
        start_pixel  = 1'b0;
        pixel        = 1'b0;
        weights_in   = '0;
        repeat (3) @(negedge clk);
        chk("rst_s0", $signed(scores[0]), 0);
        chk("rst_label", int'(label), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b1;

        // start_pixel in IDLE is ignored
        pix(1'b1);
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Test 1: weights[k]=k, all ones
        for (int k = 0; k < NC; k++) weights_in[k] = 16'(k);
        d0 = done_cnt;
        restart(1'b0);
        frame(0, 784);
        wait_done("t1", d0);
        for (int k = 0; k < NC; k++) exp_s[k] = 784 * k;
        check_res("t1", 9);

        // Test 2: all weights zero, tie to index 0
        weights_in = '0;
        d0 = done_cnt;
        restart(1'b0);
        frame(1, 784);
        wait_done("t2", d0);
        for (int k = 0; k < NC; k++) exp_s[k] = 0;
        check_res("t2", 0);

        // Test 3: overflow on class 3
        weights_in    = '0;
        weights_in[3] = 16'd100;
        d0 = done_cnt;
        restart(1'b0);
        frame(0, 784);
        wait_done("t3", d0);
`ifdef SCORE_SAT_EN
        exp_s[3] = 32767;
`else
        exp_s[3] = 12864;
`endif
        check_res("t3", 3);

        // Test 4: alternating pixels, weights[5]=-2 others 1
        for (int k = 0; k < NC; k++) weights_in[k] = 16'd1;
        weights_in[5] = 16'hFFFE;
        d0 = done_cnt;
        restart(1'b0);
        frame(1, 784);
        wait_done("t4", d0);
        for (int k = 0; k < NC; k++) exp_s[k] = 392;
        exp_s[5] = -784;
        check_res("t4", 0);

        // Test 5: abort after 400 pixels (restart coincides with a start_pixel)
        for (int k = 0; k < NC; k++) weights_in[k] = 16'(k);
        d0 = done_cnt;
        restart(1'b0);
        frame(0, 400);
        restart(1'b1);
        frame(0, 784);
        wait_done("t5", d0);
        for (int k = 0; k < NC; k++) exp_s[k] = 784 * k;
        check_res("t5", 9);

        // Test 6: reset during ARGMAX, then a clean frame
        restart(1'b0);
        frame(0, 784);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        chk("t6_busy_argmax", int'(busy), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t6_rst_s9", $signed(scores[9]), 0);
        chk("t6_rst_label", int'(label), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        repeat (20) @(negedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        restart(1'b0);
        frame(0, 784);
        wait_done("t6b", d0);
        check_res("t6b", 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
